// File: rtl/micro_sequencer_if.sv
// Microword / status bundle between the control store, datapath and the
// microaddress sequencer.
interface micro_sequencer_if;
    localparam int unsigned MW_W   = 41;
    localparam int unsigned IR_W   = 32;
    localparam int unsigned PSR_W  = 4;
    localparam int unsigned ADDR_W = 11;

    logic [MW_W-1:0]   MSEQ_MicroWord_In;
    logic [IR_W-1:0]   MSEQ_IR_In;
    logic [PSR_W-1:0]  MSEQ_PSR_In;
    logic              MSEQ_MemReady_In;
    logic [ADDR_W-1:0] MSEQ_MicroAddr_Out;
    logic              MSEQ_Stall_Out;
    logic              MSEQ_Decode_Out;
    logic              MSEQ_MemTimeout_Out;

    // CPU/ROM side: supplies microword and status, consumes the address.
    modport master (
        output MSEQ_MicroWord_In, MSEQ_IR_In, MSEQ_PSR_In, MSEQ_MemReady_In,
        input  MSEQ_MicroAddr_Out, MSEQ_Stall_Out, MSEQ_Decode_Out, MSEQ_MemTimeout_Out
    );

    // Sequencer side.
    modport slave (
        input  MSEQ_MicroWord_In, MSEQ_IR_In, MSEQ_PSR_In, MSEQ_MemReady_In,
        output MSEQ_MicroAddr_Out, MSEQ_Stall_Out, MSEQ_Decode_Out, MSEQ_MemTimeout_Out
    );
endinterface

// File: rtl/micro_sequencer.sv
// Control-store address sequencer: computes the next microaddress from the
// current microword, IR and PSR flags; stalls on memory and traps on timeout.
module micro_sequencer #(
    parameter int unsigned STALL_MAX = 16,
    parameter logic [10:0] TRAP_ADDR = 11'd2046
) (
    input logic                MSEQ_CLOCK_50,
    input logic                MSEQ_RESET_InHigh,
    micro_sequencer_if.slave   mseq_if
);
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_MAX - 32'd1);

    localparam logic [2:0] COND_INC = 3'b000;
    localparam logic [2:0] COND_N   = 3'b001;
    localparam logic [2:0] COND_Z   = 3'b010;
    localparam logic [2:0] COND_V   = 3'b011;
    localparam logic [2:0] COND_C   = 3'b100;
    localparam logic [2:0] COND_IRB = 3'b101;
    localparam logic [2:0] COND_JMP = 3'b110;
    localparam logic [2:0] COND_DEC = 3'b111;

    logic [ADDR_W-1:0] r_csar;
    logic [WAIT_W-1:0] r_wait;
    logic              r_decode;
    logic              r_timeout;

    logic              w_rd;
    logic              w_wr;
    logic [2:0]        w_cond;
    logic [ADDR_W-1:0] w_jaddr;
    logic              w_mem;
    logic              w_timeout_now;
    logic              w_stall;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_decode_addr;
    logic [ADDR_W-1:0] w_next_csar;
    logic [WAIT_W-1:0] w_next_wait;
    logic              w_next_decode;
    logic              w_next_timeout;
    logic              w_unused_bits;

    assign w_rd    = mseq_if.MSEQ_MicroWord_In[19];
    assign w_wr    = mseq_if.MSEQ_MicroWord_In[18];
    assign w_cond  = mseq_if.MSEQ_MicroWord_In[13:11];
    assign w_jaddr = mseq_if.MSEQ_MicroWord_In[10:0];

    // Datapath fields and the IR bits outside op/op3/i belong to other blocks.
    assign w_unused_bits = ^{mseq_if.MSEQ_MicroWord_In[40:20],
                             mseq_if.MSEQ_MicroWord_In[17:14],
                             mseq_if.MSEQ_IR_In[29:25],
                             mseq_if.MSEQ_IR_In[18:14],
                             mseq_if.MSEQ_IR_In[12:0]};

    assign w_mem         = w_rd | w_wr;
    assign w_timeout_now = w_mem & ~mseq_if.MSEQ_MemReady_In & (r_wait == WAIT_LAST);
    assign w_stall       = w_mem & ~mseq_if.MSEQ_MemReady_In & ~w_timeout_now;
    assign w_inc         = r_csar + ADDR_W'(1);
    assign w_decode_addr = {1'b1, mseq_if.MSEQ_IR_In[31:30], mseq_if.MSEQ_IR_In[24:19], 2'b00};

    // Next-state selection: timeout beats stall, stall beats COND dispatch.
    always_comb begin
        w_next_csar    = r_csar;
        w_next_wait    = '0;
        w_next_decode  = 1'b0;
        w_next_timeout = r_timeout;
        if (w_timeout_now) begin
            w_next_csar    = TRAP_ADDR;
            w_next_timeout = 1'b1;
        end else if (w_stall) begin
            w_next_wait = r_wait + WAIT_W'(1);
        end else begin
            unique case (w_cond)
                COND_INC: w_next_csar = w_inc;
                COND_N:   w_next_csar = mseq_if.MSEQ_PSR_In[3] ? w_jaddr : w_inc;
                COND_Z:   w_next_csar = mseq_if.MSEQ_PSR_In[2] ? w_jaddr : w_inc;
                COND_V:   w_next_csar = mseq_if.MSEQ_PSR_In[1] ? w_jaddr : w_inc;
                COND_C:   w_next_csar = mseq_if.MSEQ_PSR_In[0] ? w_jaddr : w_inc;
                COND_IRB: w_next_csar = mseq_if.MSEQ_IR_In[13] ? w_jaddr : w_inc;
                COND_JMP: w_next_csar = w_jaddr;
                COND_DEC: begin
                    w_next_csar   = w_decode_addr;
                    w_next_decode = 1'b1;
                end
                default:  w_next_csar = w_inc;
            endcase
        end
    end

    always_ff @(posedge MSEQ_CLOCK_50) begin
        if (MSEQ_RESET_InHigh) begin
            r_csar    <= '0;
            r_wait    <= '0;
            r_decode  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_csar    <= w_next_csar;
            r_wait    <= w_next_wait;
            r_decode  <= w_next_decode;
            r_timeout <= w_next_timeout;
        end
    end

    assign mseq_if.MSEQ_MicroAddr_Out  = r_csar;
    assign mseq_if.MSEQ_Stall_Out      = w_stall;
    assign mseq_if.MSEQ_Decode_Out     = r_decode;
    assign mseq_if.MSEQ_MemTimeout_Out = r_timeout;
endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: vector table plus hand-written stall, timeout,
// wrap and reset sequences, checked through an expected-result queue.
module tb_micro_sequencer;
    logic clk;
    logic rst;

    micro_sequencer_if u_if ();

    micro_sequencer #(.STALL_MAX(16), .TRAP_ADDR(11'd2046)) u_dut (
        .MSEQ_CLOCK_50     (clk),
        .MSEQ_RESET_InHigh (rst),
        .mseq_if           (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] start;
        logic        rd;
        logic        wr;
        logic [2:0]  cond;
        logic [10:0] jaddr;
        logic [31:0] ir;
        logic [3:0]  psr;
        logic        ready;
        logic [10:0] exp_addr;
        logic        exp_dec;
    } vec_t;

    typedef struct {
        logic [10:0] addr;
        logic        dec;
        logic        to;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Drive one microword for the cycle ending at the next rising edge.
    task automatic cyc(input logic r, input logic rd, input logic wr, input logic [2:0] cond,
                       input logic [10:0] jaddr, input logic [31:0] ir, input logic [3:0] psr,
                       input logic ready, input logic exp_stall, input logic [10:0] exp_addr,
                       input logic exp_dec, input logic exp_to, input string tag);
        logic [31:0] rnd;
        exp_t e;
        rnd = $urandom;
        @(negedge clk);
        rst                      = r;
        u_if.MSEQ_MicroWord_In   = {rnd[20:0], rd, wr, rnd[24:21], cond, jaddr};
        u_if.MSEQ_IR_In          = ir;
        u_if.MSEQ_PSR_In         = psr;
        u_if.MSEQ_MemReady_In    = ready;
        #1;
        n_tests++;
        if (u_if.MSEQ_Stall_Out !== exp_stall) begin
            n_fail++;
            $display("FAIL %s stall: got %b expected %b", tag, u_if.MSEQ_Stall_Out, exp_stall);
        end
        e.addr = exp_addr; e.dec = exp_dec; e.to = exp_to; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic jump(input logic [10:0] a, input logic exp_to);
        cyc(1'b0, 1'b0, 1'b0, 3'b110, a, 32'h0, 4'h0, 1'b0, 1'b0, a, 1'b0, exp_to, "jump");
    endtask

    // Registered outputs checked just after each edge against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_tests++;
            if (u_if.MSEQ_MicroAddr_Out !== e.addr) begin
                n_fail++;
                $display("FAIL %s addr: got %0d expected %0d", e.tag, u_if.MSEQ_MicroAddr_Out, e.addr);
            end
            n_tests++;
            if (u_if.MSEQ_Decode_Out !== e.dec) begin
                n_fail++;
                $display("FAIL %s decode: got %b expected %b", e.tag, u_if.MSEQ_Decode_Out, e.dec);
            end
            n_tests++;
            if (u_if.MSEQ_MemTimeout_Out !== e.to) begin
                n_fail++;
                $display("FAIL %s timeout: got %b expected %b", e.tag, u_if.MSEQ_MemTimeout_Out, e.to);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    vec_t vecs[13];

    initial begin
        rst = 1'b1;
        u_if.MSEQ_MicroWord_In = '0;
        u_if.MSEQ_IR_In        = '0;
        u_if.MSEQ_PSR_In       = '0;
        u_if.MSEQ_MemReady_In  = 1'b0;

        //          start  rd wr cond    jaddr  ir            psr      rdy  exp    dec
        vecs[0]  = '{11'd0,    1, 0, 3'b000, 11'd0,   32'h0,        4'b0000, 1, 11'd1,    0};
        vecs[1]  = '{11'd5,    0, 0, 3'b111, 11'd0,   32'h8080_0000, 4'b0000, 0, 11'd1600, 1};
        vecs[2]  = '{11'd3,    0, 0, 3'b010, 11'd12,  32'h0,        4'b0100, 0, 11'd12,   0};
        vecs[3]  = '{11'd9,    0, 0, 3'b010, 11'd12,  32'h0,        4'b1011, 0, 11'd10,   0};
        vecs[4]  = '{11'd1,    0, 0, 3'b101, 11'd40,  32'h0000_2000, 4'b0000, 0, 11'd40,   0};
        vecs[5]  = '{11'd1808, 0, 0, 3'b101, 11'd40,  32'hFFFF_DFFF, 4'b1111, 0, 11'd1809, 0};
        vecs[6]  = '{11'd2047, 0, 0, 3'b000, 11'd5,   32'h0,        4'b1111, 0, 11'd0,    0};
        vecs[7]  = '{11'd100,  0, 0, 3'b001, 11'd200, 32'h0,        4'b1000, 0, 11'd200,  0};
        vecs[8]  = '{11'd100,  0, 0, 3'b001, 11'd200, 32'h0,        4'b0111, 0, 11'd101,  0};
        vecs[9]  = '{11'd7,    0, 0, 3'b011, 11'd300, 32'h0,        4'b0010, 0, 11'd300,  0};
        vecs[10] = '{11'd7,    0, 0, 3'b100, 11'd300, 32'h0,        4'b1110, 0, 11'd8,    0};
        vecs[11] = '{11'd50,   0, 0, 3'b110, 11'd60,  32'h0,        4'b0000, 0, 11'd60,   0};
        vecs[12] = '{11'd9,    0, 0, 3'b111, 11'd0,   32'hC1F8_0000, 4'b0000, 0, 11'd2044, 1};

        cyc(1'b1, 0, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, "reset");
        cyc(1'b1, 0, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, "reset");

        foreach (vecs[i]) begin
            jump(vecs[i].start, 1'b0);
            cyc(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].cond, vecs[i].jaddr, vecs[i].ir,
                vecs[i].psr, vecs[i].ready, 1'b0, vecs[i].exp_addr, vecs[i].exp_dec, 1'b0,
                $sformatf("vec%0d", i));
        end

        // Write held for 3 un-acknowledged cycles, then acknowledged.
        jump(11'd20, 1'b0);
        repeat (3) cyc(1'b0, 0, 1, 3'b110, 11'd44, 32'h0, 4'h0, 1'b0, 1'b1, 11'd20, 1'b0, 1'b0, "wr_stall");
        cyc(1'b0, 0, 1, 3'b110, 11'd44, 32'h0, 4'h0, 1'b1, 1'b0, 11'd44, 1'b0, 1'b0, "wr_done");

        // Read never acknowledged: trap on the 16th cycle, flag sticks.
        jump(11'd5, 1'b0);
        repeat (15) cyc(1'b0, 1, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b1, 11'd5, 1'b0, 1'b0, "rd_wait");
        cyc(1'b0, 1, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b0, 11'd2046, 1'b0, 1'b1, "trap");
        cyc(1'b0, 0, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b0, 11'd2047, 1'b0, 1'b1, "post_trap");
        cyc(1'b0, 0, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b1, "wrap");

        // Acknowledge on the would-be timeout cycle completes normally.
        jump(11'd30, 1'b1);
        repeat (15) cyc(1'b0, 1, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b1, 11'd30, 1'b0, 1'b1, "late_wait");
        cyc(1'b0, 1, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b1, 1'b0, 11'd31, 1'b0, 1'b1, "late_ack");

        // Reset during a stalled DECODE word: no pulse, wait count cleared.
        jump(11'd30, 1'b1);
        repeat (3) cyc(1'b0, 1, 0, 3'b111, 11'd0, 32'h8080_0000, 4'h0, 1'b0, 1'b1, 11'd30, 1'b0, 1'b1, "pre_rst");
        cyc(1'b1, 1, 0, 3'b111, 11'd0, 32'h8080_0000, 4'h0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0, "mid_rst");
        repeat (15) cyc(1'b0, 1, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0, "post_rst_wait");
        cyc(1'b0, 1, 0, 3'b000, 11'd0, 32'h0, 4'h0, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0, "post_rst_ack");

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
